regfile_wrarb: RTL and testbench

Write-port arbiter for the multi-port `regfile`. It shares the register file's WP write ports among NR independent requesters, each using a valid/ready handshake. Each cycle it grants up to WP requests in round-robin order and never grants two requests to the same address in one cycle, because the register file ORs colliding write data. Granted writes drive registered `wr_valid`/`wr_addr`/`wr_data` buses wired directly to the `regfile` write ports.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_wrarb_sel.sv | 54 +++++
 rtl/regfile_wrarb.sv | 90 +++++++++
 tb/tb_regfile_wrarb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its write-port arbiter.
package regfile_pkg;
  localparam int AW    = 6;
  localparam int RW    = 16;
  localparam int WP    = 3;
  localparam int NR    = 6;
  localparam int CNT_W = 16;
endpackage

// File: rtl/regfile_wrarb_sel.sv
// Combinational round-robin selector: up to WP grants per cycle, no two to the same address.
module regfile_wrarb_sel #(
  parameter int AW = regfile_pkg::AW,
  parameter int WP = regfile_pkg::WP,
  parameter int NR = regfile_pkg::NR,
  localparam int IW = $clog2(NR)
) (
  input  logic [IW-1:0]          rr_ptr_i,
  input  logic [NR-1:0]          req_valid_i,
  input  logic [NR*AW-1:0]       req_addr_i,
  output logic [NR-1:0]          grant_o,
  output logic [WP-1:0][IW-1:0]  port_idx_o,
  output logic [WP-1:0]          port_vld_o,
  output logic [IW-1:0]          last_idx_o
);
  logic [AW-1:0] addr [NR];
  for (genvar i = 0; i < NR; i++) begin : g_unpack
    assign addr[i] = req_addr_i[i*AW +: AW];
  end

  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          hit;
  int            n;

  always_comb begin
    grant_o    = '0;
    port_idx_o = '0;
    port_vld_o = '0;
    last_idx_o = rr_ptr_i;
    sum        = '0;
    idx        = '0;
    hit        = 1'b0;
    n          = 0;
    for (int s = 0; s < NR; s++) begin
      sum = {1'b0, rr_ptr_i} + (IW+1)'(s);
      idx = (sum >= (IW+1)'(NR)) ? IW'(sum - (IW+1)'(NR)) : sum[IW-1:0];
      // An address already granted this cycle blocks the requester; later ones may still win.
      hit = 1'b0;
      for (int j = 0; j < NR; j++)
        if (grant_o[j] && addr[j] == addr[idx]) hit = 1'b1;
      if (req_valid_i[idx] && n < WP && !hit) begin
        grant_o[idx] = 1'b1;
        for (int k = 0; k < WP; k++)
          if (n == k) begin
            port_idx_o[k] = idx;
            port_vld_o[k] = 1'b1;
          end
        last_idx_o = idx;
        n = n + 1;
      end
    end
  end
endmodule

// File: rtl/regfile_wrarb.sv
// Write-port arbiter for the multi-port regfile: registered write buses, round-robin pointer, grant counter.
module regfile_wrarb
  import regfile_pkg::CNT_W;
#(
  parameter int AW = regfile_pkg::AW,
  parameter int RW = regfile_pkg::RW,
  parameter int WP = regfile_pkg::WP,
  parameter int NR = regfile_pkg::NR
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [NR-1:0]    req_valid,
  input  logic [NR*AW-1:0] req_addr,
  input  logic [NR*RW-1:0] req_data,
  output logic [NR-1:0]    req_ready,
  output logic [WP-1:0]    wr_valid,
  output logic [WP*AW-1:0] wr_addr,
  output logic [WP*RW-1:0] wr_data,
  output logic [CNT_W-1:0] grant_cnt
);
  localparam int IW = $clog2(NR);

  logic [IW-1:0]          rr_ptr_q, rr_ptr_d, last_idx;
  logic [NR-1:0]          grant;
  logic [WP-1:0][IW-1:0]  port_idx;
  logic [WP-1:0]          port_vld;
  logic [WP-1:0]          wr_valid_q;
  logic [WP-1:0][AW-1:0]  wr_addr_q, wr_addr_d;
  logic [WP-1:0][RW-1:0]  wr_data_q, wr_data_d;
  logic [CNT_W-1:0]       grant_cnt_q, grant_cnt_d;
  logic [CNT_W:0]         ngr, cnt_sum;

  regfile_wrarb_sel #(.AW(AW), .WP(WP), .NR(NR)) u_sel (
    .rr_ptr_i    (rr_ptr_q),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .grant_o     (grant),
    .port_idx_o  (port_idx),
    .port_vld_o  (port_vld),
    .last_idx_o  (last_idx)
  );

  assign req_ready = grant & {NR{nreset}};

  logic [AW-1:0] r_addr [NR];
  logic [RW-1:0] r_data [NR];
  for (genvar i = 0; i < NR; i++) begin : g_req
    assign r_addr[i] = req_addr[i*AW +: AW];
    assign r_data[i] = req_data[i*RW +: RW];
  end

  // Idle ports keep their last address/data so the regfile buses only toggle on writes.
  for (genvar k = 0; k < WP; k++) begin : g_port
    assign wr_addr_d[k]          = port_vld[k] ? r_addr[port_idx[k]] : wr_addr_q[k];
    assign wr_data_d[k]          = port_vld[k] ? r_data[port_idx[k]] : wr_data_q[k];
    assign wr_addr[k*AW +: AW]   = wr_addr_q[k];
    assign wr_data[k*RW +: RW]   = wr_data_q[k];
  end
  assign wr_valid  = wr_valid_q;
  assign grant_cnt = grant_cnt_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant)
      rr_ptr_d = (last_idx == IW'(NR-1)) ? '0 : last_idx + IW'(1);
  end

  always_comb begin
    ngr = '0;
    for (int k = 0; k < WP; k++) ngr = ngr + (CNT_W+1)'(port_vld[k]);
    cnt_sum     = {1'b0, grant_cnt_q} + ngr;
    grant_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr_q    <= '0;
      wr_valid_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_valid_q  <= port_vld;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_wrarb.sv
// Scoreboard bench for regfile_wrarb: directed scenarios plus randomized traffic against a spec-level model.
module tb_regfile_wrarb;
  localparam int AW = 6, RW = 16, WP = 3, NR = 6;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*RW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic [WP-1:0]    wr_valid;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*RW-1:0] wr_data;
  logic [15:0]      grant_cnt;

  always #5 clk = ~clk;

  regfile_wrarb #(.AW(AW), .RW(RW), .WP(WP), .NR(NR)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .grant_cnt(grant_cnt)
  );

  typedef struct {
    logic [WP-1:0]    v;
    logic [WP*AW-1:0] a;
    logic [WP*RW-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;

  // requester-side state and reference model
  logic          rv [NR];
  logic [AW-1:0] ra [NR];
  logic [RW-1:0] rd [NR];
  int            m_ptr = 0;
  int            m_cnt = 0;
  logic [AW-1:0] m_wa [WP];
  logic [RW-1:0] m_wd [WP];
  logic [RW-1:0] rf [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = rv[i];
      req_addr[i*AW +: AW]   = ra[i];
      req_data[i*RW +: RW]   = rd[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    for (int k = 0; k < WP; k++) begin
      m_wa[k] = '0;
      m_wd[k] = '0;
    end
  endtask

  // Drive the pins, then grant by scanning from the pointer under the WP and unique-address limits.
  task automatic step();
    logic [NR-1:0] g;
    logic [AW-1:0] used [WP];
    exp_t e;
    int n, last, i;
    bit hit;
    apply();
    #1;
    g = '0; n = 0; last = 0; e.v = '0; e.a = '0; e.d = '0;
    for (int s = 0; s < NR; s++) begin
      i = (m_ptr + s) % NR;
      hit = 1'b0;
      for (int k = 0; k < n; k++) if (used[k] == ra[i]) hit = 1'b1;
      if (rv[i] && n < WP && !hit) begin
        g[i] = 1'b1;
        used[n] = ra[i];
        m_wa[n] = ra[i];
        m_wd[n] = rd[i];
        e.v[n] = 1'b1;
        last = i;
        n++;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(g));
    if (n > 0) begin
      m_ptr = (last + 1) % NR;
      m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
      for (int k = 0; k < WP; k++) begin
        e.a[k*AW +: AW] = m_wa[k];
        e.d[k*RW +: RW] = m_wd[k];
      end
      exp_q.push_back(e);
    end
    for (int j = 0; j < NR; j++) if (g[j]) rv[j] = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) rv[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    model_reset();
    exp_q.delete();
    idle_all();
    apply();
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic set_req(input int i, input int a, input int d);
    rv[i] = 1'b1;
    ra[i] = AW'(a);
    rd[i] = RW'(d);
  endtask

  // monitor: pops the scoreboard whenever the write buses carry a write
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (nreset) begin
        chk("grant_cnt", 64'(grant_cnt), 64'(m_cnt[15:0]));
        if (wr_valid != '0) begin
          if (exp_q.size() == 0) chk("unexpected_wr", 64'(wr_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("wr_valid", 64'(wr_valid), 64'(e.v));
            chk("wr_addr", 64'(wr_addr), 64'(e.a));
            chk("wr_data", 64'(wr_data), 64'(e.d));
          end
        end
      end
    end
  end

  // regfile image: captures the buses at the edge that ends their cycle
  initial begin : rfm
    logic [WP-1:0]    pv;
    logic [WP*AW-1:0] pa;
    logic [WP*RW-1:0] pd;
    forever begin
      @(negedge clk);
      pv = wr_valid; pa = wr_addr; pd = wr_data;
      @(posedge clk);
      if (nreset)
        for (int k = 0; k < WP; k++) if (pv[k]) rf[pa[k*AW +: AW]] = pd[k*RW +: RW];
    end
  end

  initial begin
    for (int a = 0; a < 64; a++) rf[a] = '0;
    model_reset();
    // reset held with every requester valid
    for (int i = 0; i < NR; i++) set_req(i, i, 16'h1000 + i);
    apply();
    #12;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_cnt", 64'(grant_cnt), 64'd0);
    @(negedge clk);
    nreset = 1'b1;
    step();
    chk("first_grant", 64'(req_ready), 64'h07);
    @(posedge clk); #2;
    chk("first_ptr", 64'(dut.rr_ptr_q), 64'd3);

    // round robin over distinct addresses
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NR; i++) set_req(i, i, 16'h2000 + c*16 + i);
      cycle();
      chk("rr_grant", 64'(req_ready), (c % 2 == 0) ? 64'h07 : 64'h38);
    end
    idle_all();
    cycle();
    chk("rr_cnt", 64'(grant_cnt), 64'd12);

    // address conflict
    do_reset();
    set_req(0, 7, 16'hA000); set_req(1, 7, 16'hA001);
    set_req(2, 9, 16'hA002); set_req(3, 7, 16'hA003);
    cycle(); chk("conf_c1", 64'(req_ready), 64'h05);
    cycle(); chk("conf_c2", 64'(req_ready), 64'h08);
    cycle(); chk("conf_c3", 64'(req_ready), 64'h02);
    cycle(); cycle();
    chk("conf_rf7", 64'(rf[7]), 64'hA001);
    chk("conf_rf9", 64'(rf[9]), 64'hA002);

    // sparse requests across the wrap point
    do_reset();
    for (int i = 0; i < 5; i++) set_req(i, 10 + i, 16'hB000 + i);
    cycle(); chk("sp_c1", 64'(req_ready), 64'h07);
    cycle(); chk("sp_c2", 64'(req_ready), 64'h18);
    set_req(5, 20, 16'hB005); set_req(0, 21, 16'hB006);
    cycle(); chk("sp_c3", 64'(req_ready), 64'h21);
    @(posedge clk); #2;
    chk("sp_wr_valid", 64'(wr_valid), 64'b011);
    chk("sp_ptr", 64'(dut.rr_ptr_q), 64'd1);

    // reset while writes are in flight
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 40 + i, 16'hC000 + i);
    cycle();
    for (int i = 0; i < NR; i++) set_req(i, 40 + i, 16'hC100 + i);
    @(negedge clk);
    step();
    nreset = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    chk("mid_wr_valid", 64'(wr_valid), 64'd0);
    chk("mid_ready", 64'(req_ready), 64'd0);
    chk("mid_cnt", 64'(grant_cnt), 64'd0);
    chk("mid_ptr", 64'(dut.rr_ptr_q), 64'd0);
    @(posedge clk); #2;
    chk("mid_wr_valid_hold", 64'(wr_valid), 64'd0);
    idle_all();
    apply();
    @(negedge clk);
    nreset = 1'b1;
    cycle(); cycle();
    for (int a = 40; a < 46; a++) chk("mid_rf_untouched", 64'(rf[a]), 64'd0);

    // counter saturation
    @(negedge clk);
    #2;
    force dut.grant_cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.grant_cnt_q;
    for (int i = 0; i < 3; i++) set_req(i, 50 + i, 16'hD000 + i);
    cycle();
    for (int i = 3; i < 6; i++) set_req(i, 50 + i, 16'hD000 + i);
    cycle();
    idle_all();
    cycle();
    chk("sat_cnt", 64'(grant_cnt), 64'hFFFF);
    cycle();
    chk("sat_hold", 64'(grant_cnt), 64'hFFFF);

    // randomized traffic with conflicts and dropped requests
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (rv[i] && $urandom_range(0, 15) == 0) rv[i] = 1'b0;
        else if (!rv[i] && $urandom_range(0, 2) != 0)
          set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
      end
      cycle();
    end
    idle_all();
    cycle(); cycle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
